// File: rtl/bip_debug_link.sv
// UART control/report link for the BIP CPU: holds the CPU in reset until a start byte,
// counts run cycles, and on halt streams {hdr, acc, pc, cnt} LSB-first to the UART TX.
module bip_debug_link #(
    parameter int                   NB_DATA     = 8,
    parameter int                   NB_OPCODE   = 5,
    parameter int                   NB_ADDR     = 11,
    parameter int                   RAM_WIDTH   = 16,
    parameter int                   NB_CNT      = 16,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = '0,
    parameter logic [NB_DATA-1:0]   START_CMD   = 8'h53,
    parameter logic [NB_DATA-1:0]   FRAME_HDR   = 8'hA5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [RAM_WIDTH-1:0] i_acc,
    input  logic [NB_ADDR-1:0]   i_pc,
    input  logic                 i_tx_done,
    output logic                 o_tx_valid,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_cpu_run,
    output logic                 o_frame_done
);
    localparam int NA = (RAM_WIDTH + NB_DATA - 1) / NB_DATA;
    localparam int NP = (NB_ADDR + NB_DATA - 1) / NB_DATA;
    localparam int NC = (NB_CNT + NB_DATA - 1) / NB_DATA;
    localparam int L  = 1 + NA + NP + NC;
    localparam int NI = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, RUN, SEND, DONE} state_t;

    state_t              r_state, w_state_next;
    logic                r_rx_prev, r_tx_prev;
    logic                w_rx_edge, w_tx_edge, w_halt, w_start, w_last;
    logic [NB_CNT-1:0]   r_cnt, w_cnt_inc, r_cnt_snap;
    logic [RAM_WIDTH-1:0] r_acc;
    logic [NB_ADDR-1:0]  r_pc;
    logic [NI-1:0]       r_idx;
    logic                r_frame_done;
    logic [L*NB_DATA-1:0] w_frame;

    assign w_rx_edge = i_rx_done & ~r_rx_prev;
    assign w_tx_edge = i_tx_done & ~r_tx_prev;
    assign w_halt    = (i_opcode == HALT_OPCODE);
    assign w_start   = w_rx_edge && (i_rx_data == START_CMD);
    assign w_last    = (r_idx == NI'(L - 1));
    // Saturating increment: the count sticks at all-ones on long runs.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (w_halt) w_state_next = SEND;
            SEND:    if (w_tx_edge && w_last) w_state_next = DONE;
            DONE:    if (w_start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_rx_prev    <= 1'b0;
            r_tx_prev    <= 1'b0;
            r_cnt        <= '0;
            r_cnt_snap   <= '0;
            r_acc        <= '0;
            r_pc         <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rx_prev    <= i_rx_done;
            r_tx_prev    <= i_tx_done;
            r_frame_done <= (r_state == SEND) && w_tx_edge && w_last;
            if (r_state != RUN && w_state_next == RUN)
                r_cnt <= '0;
            else if (r_state == RUN)
                r_cnt <= w_cnt_inc;
            // The snapshot count includes the halt cycle itself.
            if (r_state == RUN && w_halt) begin
                r_acc      <= i_acc;
                r_pc       <= i_pc;
                r_cnt_snap <= w_cnt_inc;
                r_idx      <= '0;
            end else if (r_state == SEND && w_tx_edge && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_frame = '0;
        w_frame[NB_DATA-1:0]                     = FRAME_HDR;
        w_frame[NB_DATA +: RAM_WIDTH]            = r_acc;
        w_frame[(1 + NA) * NB_DATA +: NB_ADDR]   = r_pc;
        w_frame[(1 + NA + NP) * NB_DATA +: NB_CNT] = r_cnt_snap;
    end

    assign o_cpu_run    = (r_state == RUN);
    assign o_tx_valid   = (r_state == SEND);
    assign o_tx_data    = o_tx_valid ? w_frame[r_idx * NB_DATA +: NB_DATA] : '0;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_bip_debug_link.sv
// Bench for bip_debug_link: a default instance and a 4-bit-counter instance share stimulus;
// expected frames come from a byte-level model of the report format.
module tb_bip_debug_link;
    localparam int NBC1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [4:0]  opcode;
    logic [15:0] acc;
    logic [10:0] pc;
    logic        tx_done;
    logic        tx_valid [2];
    logic [7:0]  tx_data [2];
    logic        cpu_run [2];
    logic        frame_done [2];

    logic [7:0]  exp_fr [2][8];
    int          exp_len [2];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bip_debug_link u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_opcode(opcode), .i_acc(acc), .i_pc(pc), .i_tx_done(tx_done),
        .o_tx_valid(tx_valid[0]), .o_tx_data(tx_data[0]),
        .o_cpu_run(cpu_run[0]), .o_frame_done(frame_done[0])
    );

    bip_debug_link #(.NB_CNT(NBC1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_opcode(opcode), .i_acc(acc), .i_pc(pc), .i_tx_done(tx_done),
        .o_tx_valid(tx_valid[1]), .o_tx_data(tx_data[1]),
        .o_cpu_run(cpu_run[1]), .o_frame_done(frame_done[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, then each field split into whole bytes, LSB first.
    task automatic build_frames(input logic [15:0] a, input logic [10:0] p, input int n);
        for (int d = 0; d < 2; d++) begin
            int nb, cmax, c, k;
            nb   = (d == 0) ? 16 : NBC1;
            cmax = (1 << nb) - 1;
            c    = (n > cmax) ? cmax : n;
            k    = 0;
            exp_fr[d][k] = 8'hA5; k++;
            for (int b = 0; b < (16 + 7) / 8; b++) begin exp_fr[d][k] = 8'(int'(a) >> (8 * b)); k++; end
            for (int b = 0; b < (11 + 7) / 8; b++) begin exp_fr[d][k] = 8'(int'(p) >> (8 * b)); k++; end
            for (int b = 0; b < (nb + 7) / 8; b++) begin exp_fr[d][k] = 8'(c >> (8 * b)); k++; end
            exp_len[d] = k;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic check_quiet(input string name, input logic run_exp);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (tx_valid[d] !== 1'b0 || tx_data[d] !== 8'h00 || cpu_run[d] !== run_exp || frame_done[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: valid=%b data=%h run=%b done=%b, want 0 00 %b 0",
                         name, d, tx_valid[d], tx_data[d], cpu_run[d], frame_done[d], run_exp);
            end
        end
    endtask

    // Runs n RUN cycles (last one is the halt), optional RX noise, ends in SEND.
    task automatic do_run(input int n, input logic [15:0] a, input logic [10:0] p, input bit noise);
        for (int i = 0; i < n - 1; i++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (cpu_run[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_active dut%0d cycle %0d: run=%b want 1", d, i, cpu_run[d]);
                end
            end
            opcode  = 5'($urandom_range(1, 31));
            acc     = 16'($urandom);
            pc      = 11'($urandom);
            rx_data = 8'h53;
            rx_done = noise && (i != n - 2) ? 1'($urandom) : 1'b0;
            step();
        end
        opcode  = 5'd0;
        acc     = a;
        pc      = p;
        rx_data = 8'h53;
        rx_done = noise;
        step();
        rx_done = 1'b0;
        opcode  = 5'($urandom_range(1, 31));
        build_frames(a, p, n);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cpu_run[d] !== 1'b0 || tx_valid[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL enter_send dut%0d: run=%b valid=%b want 0 1", d, cpu_run[d], tx_valid[d]);
            end
        end
    endtask

    task automatic recv_frame(input bit disturb);
        int min_len;
        min_len = (exp_len[0] < exp_len[1]) ? exp_len[0] : exp_len[1];
        for (int k = 0; k < 7; k++) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] want;
                logic       wv;
                wv   = (k < exp_len[d]);
                want = wv ? exp_fr[d][k] : 8'h00;
                n_checks++;
                if (tx_valid[d] !== wv || tx_data[d] !== want) begin
                    n_fail++;
                    $display("FAIL frame_byte dut%0d idx %0d: valid=%b data=%h want %b %h",
                             d, k, tx_valid[d], tx_data[d], wv, want);
                end
            end
            if (disturb && k < min_len) begin
                acc = 16'($urandom); pc = 11'($urandom); rx_data = 8'h53; rx_done = 1'b1;
            end
            tx_done = 1'b1;
            step();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (frame_done[d] !== (k == exp_len[d] - 1)) begin
                    n_fail++;
                    $display("FAIL frame_done dut%0d idx %0d: got %b want %b", d, k, frame_done[d], k == exp_len[d] - 1);
                end
            end
            rx_done = 1'b0;
            tx_done = 1'b0;
            step();
        end
        check_quiet("done_state", 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; opcode = 5'd1; acc = '0; pc = '0; tx_done = 1'b0;
        step(); step();
        check_quiet("reset_outputs", 1'b0);
        rst = 1'b0;
        step();
        send_rx(8'h41);
        step(); step();
        check_quiet("idle_ignores_byte", 1'b0);
    endtask

    task automatic test_basic_frame();
        send_rx(8'h53);
        do_run(10, 16'hBEEF, 11'h5A3, 1'b0);
        recv_frame(1'b1);
        for (int i = 0; i < 3; i++) begin
            tx_done = 1'b1; step(); tx_done = 1'b0; step();
        end
        check_quiet("done_ignores_tx", 1'b0);
    endtask

    task automatic test_hold_tx();
        send_rx(8'h53);
        tx_done = 1'b1;
        do_run(6, 16'h1234, 11'h7FF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (tx_valid[d] !== 1'b1 || tx_data[d] !== 8'hA5 || frame_done[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_tx dut%0d: valid=%b data=%h done=%b want 1 a5 0",
                             d, tx_valid[d], tx_data[d], frame_done[d]);
                end
            end
            step();
        end
        tx_done = 1'b0;
        step();
        recv_frame(1'b0);
    endtask

    task automatic test_rerun();
        check_quiet("rerun_before", 1'b0);
        send_rx(8'h53);
        do_run(3, 16'h00C3, 11'h010, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (exp_fr[d][exp_len[d] - 1] !== ((d == 0) ? 8'h00 : 8'h03) || exp_fr[d][5] !== 8'h03) begin
                n_fail++;
                $display("FAIL rerun_model dut%0d: cnt byte %h want 03", d, exp_fr[d][5]);
            end
        end
        recv_frame(1'b0);
    endtask

    task automatic test_saturate();
        send_rx(8'h53);
        do_run(20, 16'hCAFE, 11'h123, 1'b0);
        n_checks++;
        if (tx_valid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_send: valid=%b want 1", tx_valid[1]);
        end
        recv_frame(1'b0);
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 6; it++) begin
            int n;
            n = (it == 0) ? 1 : $urandom_range(2, 40);
            send_rx(8'h53);
            do_run(n, 16'($urandom), 11'($urandom), 1'b1);
            recv_frame(it[0]);
        end
    endtask

    task automatic test_reset_mid_send();
        send_rx(8'h53);
        do_run(7, 16'h8001, 11'h400, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tx_done = 1'b1; step(); tx_done = 1'b0; step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_quiet("async_reset", 1'b0);
        step(); step();
        rst = 1'b0;
        step();
        send_rx(8'h41);
        step();
        check_quiet("post_reset_idle", 1'b0);
        send_rx(8'h53);
        do_run(5, 16'h0F0F, 11'h0AA, 1'b0);
        recv_frame(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_tx();
        test_rerun();
        test_saturate();
        test_random_runs();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
